// File: rtl/edge_capture_pkg.sv
// Shared types and parameter defaults for the multi-channel edge capture block.
package edge_capture_pkg;

  typedef enum logic [1:0] {
    EDGE_NONE = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_mode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ARMED = 2'b01,
    DONE  = 2'b10
  } capture_state_t;

  localparam int DEF_NUM_CHANNELS  = 4;
  localparam int DEF_SYNC_STAGES   = 2;
  localparam int DEF_FILTER_CYCLES = 3;
  localparam int DEF_TS_WIDTH      = 16;

  // A filter length of zero behaves as a single-sample filter.
  function automatic int eff_filter(input int fc);
    return (fc < 1) ? 1 : fc;
  endfunction

endpackage

// File: rtl/edge_channel.sv
// One input bit: synchronizer chain, stability filter and registered edge detector.
module edge_channel
  import edge_capture_pkg::*;
#(
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int FILTER_CYCLES = DEF_FILTER_CYCLES
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in,
  input  edge_mode_t mode,
  output logic       filtered,
  output logic       edge_pulse
);

  localparam int F  = eff_filter(FILTER_CYCLES);
  localparam int CW = $clog2(F + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(F - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_cnt;
  logic                   r_filt;
  logic                   r_filt_d;
  logic                   r_pulse;
  logic                   w_sync;
  logic                   w_rise;
  logic                   w_fall;
  logic                   w_pulse;

  assign w_sync = r_sync[SYNC_STAGES-1];
  assign w_rise = r_filt & ~r_filt_d;
  assign w_fall = ~r_filt & r_filt_d;

  always_comb begin
    w_pulse = 1'b0;
    case (mode)
      EDGE_RISE: w_pulse = w_rise;
      EDGE_FALL: w_pulse = w_fall;
      EDGE_BOTH: w_pulse = w_rise | w_fall;
      default:   w_pulse = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync   <= '0;
      r_cnt    <= '0;
      r_filt   <= 1'b0;
      r_filt_d <= 1'b0;
      r_pulse  <= 1'b0;
    end else begin
      r_sync   <= {r_sync[SYNC_STAGES-2:0], in};
      r_filt_d <= r_filt;
      r_pulse  <= w_pulse;
      // Level only follows the synchronized input after F consecutive mismatching samples.
      if (w_sync != r_filt) begin
        if (r_cnt == CNT_LAST) begin
          r_filt <= w_sync;
          r_cnt  <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign filtered   = r_filt;
  assign edge_pulse = r_pulse;

endmodule

// File: rtl/multi_edge_capture.sv
// Per-channel edge conditioning plus a shared arm/capture FSM that timestamps the first edge per channel.
module multi_edge_capture
  import edge_capture_pkg::*;
#(
  parameter int NUM_CHANNELS  = DEF_NUM_CHANNELS,
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int FILTER_CYCLES = DEF_FILTER_CYCLES,
  parameter int TS_WIDTH      = DEF_TS_WIDTH
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [NUM_CHANNELS-1:0]                in,
  input  logic [1:0]                             mode,
  input  logic                                   arm,
  output logic [NUM_CHANNELS-1:0]                filtered,
  output logic [NUM_CHANNELS-1:0]                edge_pulse,
  output logic [NUM_CHANNELS-1:0][TS_WIDTH-1:0]  timestamp,
  output logic [NUM_CHANNELS-1:0]                ts_valid,
  output logic                                   armed,
  output logic                                   done,
  output logic                                   timeout
);

  localparam logic [TS_WIDTH-1:0] CNT_MAX = '1;

  edge_mode_t                            w_mode;
  capture_state_t                        r_state;
  capture_state_t                        w_state_nxt;
  logic [TS_WIDTH-1:0]                   r_cnt;
  logic [TS_WIDTH-1:0]                   w_cnt_nxt;
  logic [NUM_CHANNELS-1:0][TS_WIDTH-1:0] r_ts;
  logic [NUM_CHANNELS-1:0][TS_WIDTH-1:0] w_ts_nxt;
  logic [NUM_CHANNELS-1:0]               r_vld;
  logic [NUM_CHANNELS-1:0]               w_vld_nxt;
  logic [NUM_CHANNELS-1:0]               w_cap;
  logic                                  r_timeout;
  logic                                  w_timeout_nxt;

  assign w_mode = edge_mode_t'(mode);

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
    edge_channel #(
      .SYNC_STAGES   (SYNC_STAGES),
      .FILTER_CYCLES (FILTER_CYCLES)
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .in         (in[g]),
      .mode       (w_mode),
      .filtered   (filtered[g]),
      .edge_pulse (edge_pulse[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_ts      <= '0;
      r_vld     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_ts      <= w_ts_nxt;
      r_vld     <= w_vld_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_ts_nxt      = r_ts;
    w_vld_nxt     = r_vld;
    w_timeout_nxt = r_timeout;
    w_cap         = '0;
    // Arm restarts the window from any state and takes priority over a same-cycle edge.
    if (arm) begin
      w_state_nxt   = ARMED;
      w_cnt_nxt     = '0;
      w_vld_nxt     = '0;
      w_timeout_nxt = 1'b0;
    end else if (r_state == ARMED) begin
      w_cap     = edge_pulse & ~r_vld;
      w_vld_nxt = r_vld | w_cap;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        if (w_cap[i]) w_ts_nxt[i] = r_cnt;
      end
      if (&w_vld_nxt) begin
        w_state_nxt = DONE;
      end else if (r_cnt == CNT_MAX) begin
        w_state_nxt   = DONE;
        w_timeout_nxt = 1'b1;
      end else begin
        w_cnt_nxt = r_cnt + 1'b1;
      end
    end
  end

  assign timestamp = r_ts;
  assign ts_valid  = r_vld;
  assign timeout   = r_timeout;
  assign armed     = (r_state == ARMED);
  assign done      = (r_state == DONE);

endmodule

// File: tb/tb_multi_edge_capture.sv
// Directed bench for multi_edge_capture: filter latency, glitch rejection, edge modes and capture windows.
module tb_multi_edge_capture;

  logic             clk;
  logic             rst_n;
  logic [3:0]       in;
  logic [1:0]       mode;
  logic             arm;
  logic [3:0]       filtered;
  logic [3:0]       edge_pulse;
  logic [3:0][15:0] timestamp;
  logic [3:0]       ts_valid;
  logic             armed;
  logic             done;
  logic             timeout;

  logic [3:0]       in4;
  logic             arm4;
  logic [3:0]       filtered4;
  logic [3:0]       edge_pulse4;
  logic [3:0][3:0]  timestamp4;
  logic [3:0]       ts_valid4;
  logic             armed4;
  logic             done4;
  logic             timeout4;

  int vectors;
  int miscompares;
  int n;
  logic flag;

  multi_edge_capture dut (
    .clk(clk), .rst_n(rst_n), .in(in), .mode(mode), .arm(arm),
    .filtered(filtered), .edge_pulse(edge_pulse), .timestamp(timestamp),
    .ts_valid(ts_valid), .armed(armed), .done(done), .timeout(timeout)
  );

  multi_edge_capture #(.TS_WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in(in4), .mode(mode), .arm(arm4),
    .filtered(filtered4), .edge_pulse(edge_pulse4), .timestamp(timestamp4),
    .ts_valid(ts_valid4), .armed(armed4), .done(done4), .timeout(timeout4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step_count(input int ch, input logic val, output int cnt);
    in[ch] = val;
    cnt = 0;
    repeat (12) begin
      tick;
      if (edge_pulse[ch]) cnt++;
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0;
    in = '0;
    in4 = '0;
    mode = 2'b01;
    arm = 1'b0;
    arm4 = 1'b0;

    repeat (3) tick;
    check("rst_filtered", filtered, 0);
    check("rst_pulse", edge_pulse, 0);
    check("rst_ts", timestamp, 0);
    check("rst_valid", ts_valid, 0);
    check("rst_flags", {armed, done, timeout}, 0);
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick;
      check("idle_pulse", edge_pulse, 0);
    end

    // Rising step on channel 0: pulse after the sixth edge from first sampling
    in[0] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick;
      check("lat_quiet", edge_pulse, 0);
    end
    check("lat_filt", filtered, 4'b0001);
    tick;
    check("lat_pulse", edge_pulse, 4'b0001);
    tick;
    check("lat_one", edge_pulse, 0);

    in[1] = 1'b1;
    tick;
    tick;
    in[1] = 1'b0;
    flag = 1'b0;
    repeat (10) begin
      tick;
      if (filtered[1] || edge_pulse[1]) flag = 1'b1;
    end
    check("glitch", flag, 0);

    step_count(0, 1'b0, n);
    check("rise_mode_fall", n, 0);
    check("fall_filt", filtered[0], 0);

    mode = 2'b10;
    step_count(2, 1'b1, n);
    check("m10_rise", n, 0);
    check("m10_filt", filtered[2], 1);
    step_count(2, 1'b0, n);
    check("m10_fall", n, 1);
    mode = 2'b11;
    step_count(2, 1'b1, n);
    check("m11_rise", n, 1);
    step_count(2, 1'b0, n);
    check("m11_fall", n, 1);
    mode = 2'b00;
    step_count(2, 1'b1, n);
    check("m00_rise", n, 0);
    step_count(2, 1'b0, n);
    check("m00_fall", n, 0);

    // Four-channel capture window
    mode = 2'b01;
    arm = 1'b1;
    tick;
    arm = 1'b0;
    check("arm_state", {armed, done, timeout}, 3'b100);
    check("arm_valid", ts_valid, 0);
    for (int c = 0; c < 50; c++) begin
      if (c == 9)  in[0] = 1'b1;
      if (c == 24) in[2:1] = 2'b11;
      if (c == 39) in[3] = 1'b1;
      tick;
      if (c + 1 == 15) check("cap_v15", ts_valid, 0);
      if (c + 1 == 16) check("cap_v16", ts_valid, 4'b0001);
      if (c + 1 == 31) check("cap_v31", ts_valid, 4'b0111);
      if (c + 1 == 45) check("cap_done45", {done, ts_valid}, 5'b00111);
      if (c + 1 == 46) check("cap_done46", done, 1);
    end
    check("cap_ts0", timestamp[0], 15);
    check("cap_ts1", timestamp[1], 30);
    check("cap_ts2", timestamp[2], 30);
    check("cap_ts3", timestamp[3], 45);
    check("cap_valid", ts_valid, 4'b1111);
    check("cap_flags", {armed, done, timeout}, 3'b010);

    // Counter saturation on the 4-bit instance
    arm4 = 1'b1;
    tick;
    arm4 = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (c == 4) in4[0] = 1'b1;
      tick;
      if (c + 1 == 15) check("to_pre", {armed4, done4, timeout4}, 3'b100);
      if (c + 1 == 16) check("to_hit", {armed4, done4, timeout4}, 3'b011);
    end
    check("to_valid", ts_valid4, 4'b0001);
    check("to_ts0", timestamp4[0], 10);

    in4 = '0;
    repeat (12) tick;
    arm4 = 1'b1;
    tick;
    arm4 = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (c == 9) in4 = 4'b1111;
      tick;
      if (c + 1 == 16) check("max_done", {armed4, done4, timeout4}, 3'b010);
    end
    check("max_valid", ts_valid4, 4'b1111);
    check("max_ts", timestamp4, 16'hFFFF);

    // Re-arm from DONE, then arm colliding with a channel-2 pulse
    in = '0;
    repeat (12) tick;
    arm = 1'b1;
    tick;
    arm = 1'b0;
    check("rearm_state", {armed, done}, 2'b10);
    check("rearm_valid", ts_valid, 0);
    for (int c = 0; c < 16; c++) begin
      if (c == 9)  in[2] = 1'b1;
      if (c == 15) arm = 1'b1;
      tick;
      if (c + 1 == 15) check("coll_pulse", edge_pulse, 4'b0100);
    end
    arm = 1'b0;
    check("coll_valid", ts_valid, 0);
    check("coll_armed", armed, 1);
    check("coll_keep_ts2", timestamp[2], 30);
    for (int c = 0; c < 21; c++) begin
      if (c == 9) in[3] = 1'b1;
      tick;
    end
    check("restart_valid", ts_valid, 4'b1000);
    check("restart_ts3", timestamp[3], 15);
    check("restart_keep_ts0", timestamp[0], 15);
    check("restart_armed", armed, 1);

    // Asynchronous reset while the window is open
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_flags", {armed, done, timeout}, 0);
    check("arst_valid", ts_valid, 0);
    check("arst_ts", timestamp, 0);
    check("arst_filt", filtered, 0);
    check("arst_pulse", edge_pulse, 0);
    tick;
    rst_n = 1'b1;
    tick;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/multi_edge_capture.md
Name: multi_edge_capture

Overview:
- Multi-channel successor to the single-bit positive-edge detector.
- Per channel it provides:
  - a synchronizer for async inputs (e.g. microphone threshold comparators);
  - a glitch filter;
  - a runtime-selectable edge mode: rising, falling or both.
- A shared arm/capture state machine timestamps the first qualifying edge on every channel with a common free-running counter.
- Feeds time-difference-of-arrival logic in the correlation path.

Parameters:
- NUM_CHANNELS, 4: number of independent input channels (≥1).
- SYNC_STAGES, 2: synchronizer flops per channel (≥2).
- FILTER_CYCLES, 3: consecutive stable samples required before the filtered level changes (0 treated as 1).
- TS_WIDTH, 16: timestamp counter width.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous, active-low reset.
- in  in  NUM_CHANNELS  raw asynchronous input levels.
- mode  in  2  edge mode: 00 none, 01 rising, 10 falling, 11 both.
- arm  in  1  single-cycle request to start a capture window.
- filtered  out  NUM_CHANNELS  debounced level per channel.
- edge_pulse  out  NUM_CHANNELS  one-cycle pulse per qualifying edge.
- timestamp  out  NUM_CHANNELS x TS_WIDTH  captured counter value per channel (packed 2-D).
- ts_valid  out  NUM_CHANNELS  timestamp of that channel is valid.
- armed  out  1  capture window open.
- done  out  1  window closed (all captured or timeout).
- timeout  out  1  window closed by counter saturation.

Behaviour:
- Reset (rst_n low, asynchronous) forces all outputs and internal state to 0:
  - sync flops, filtered, edge_pulse, filter counters;
  - timestamp, ts_valid, counter;
  - state = IDLE, armed, done, timeout.
- Synchronizer: in[i] passes through SYNC_STAGES flops; sync[i] denotes the last stage.
- Filter, per channel:
  - Counter increments while sync[i] != filtered[i] and resets to 0 when they are equal.
  - filtered[i] takes sync[i] on the edge where the mismatch has lasted F = max(FILTER_CYCLES,1) consecutive samples; the counter then clears.
  - A pulse shorter than F samples never reaches filtered.
- Edge detect (registered):
  - edge_pulse[i] is high for exactly one cycle after filtered[i] changes, if the direction matches mode.
  - mode 00 suppresses all pulses.
  - mode is sampled every cycle, so a change applies to the next filtered transition.
- Latency: a step on in, stable from clock edge t, gives edge_pulse high in the cycle after edge t+SYNC_STAGES+F. Defaults: 6 cycles.
- Capture FSM states: IDLE, ARMED, DONE.
  - IDLE→ARMED on arm: counter:=0, ts_valid:=0, timeout:=0, done:=0.
  - ARMED:
    - counter increments by 1 each cycle;
    - in any cycle where edge_pulse[i]=1 and ts_valid[i]=0, timestamp[i]:=counter and ts_valid[i]:=1;
    - later edges on that channel are ignored.
  - ARMED→DONE when all ts_valid are set (including bits set this cycle); counter holds.
  - ARMED→DONE with timeout:=1 when counter = 2^TS_WIDTH−1 and the window is not complete.
    - An edge in that same cycle is still captured, with value 2^TS_WIDTH−1.
    - If that capture completes the set, timeout stays 0.
  - DONE→ARMED on arm, same clearing as from IDLE. timestamp values are retained until overwritten.
- armed = (state==ARMED); done = (state==DONE).
- Simultaneous events:
  - arm in ARMED restarts the window.
  - arm in the same cycle as an edge_pulse: arm wins and that edge is not captured.
  - Multiple channels pulsing in one cycle all capture the same value.
- edge_pulse and filtered run continuously in every state; capture only in ARMED.
- Reset mid-window returns to IDLE with all flags and timestamps cleared.

Decomposition:
- Package edge_capture_pkg holds:
  - edge_mode_t enum (EDGE_NONE, EDGE_RISE, EDGE_FALL, EDGE_BOTH);
  - capture_state_t enum (IDLE, ARMED, DONE);
  - parameter defaults.
- One sub-module, edge_channel, contains synchronizer, filter and edge detect for one bit. It is instantiated NUM_CHANNELS times via generate.
- The top level holds the FSM, counter and timestamp registers.

Test Plan:
- Reset then idle: rst_n low 3 cycles → all outputs 0; with in=0 and mode=01 held 20 cycles → no edge_pulse.
- Latency and glitch:
  - mode=01, in[0] 0→1 stable → edge_pulse[0] high exactly one cycle, 6 cycles after the first sampling edge.
  - A 2-cycle high glitch on in[1] → no filtered change and no pulse.
- Modes on a 0→1→0 sequence:
  - mode=10 → pulse only on the fall;
  - mode=11 → two pulses;
  - mode=00 → none.
- Capture:
  - arm at cycle 0, then raise in[0..3] at cycles 10, 25, 25, 40 (mode=01) → timestamps 15, 30, 30, 45 (arm edge + 6 latency − 1);
  - ts_valid fills to 1111, then done=1 and timeout=0.
- Timeout: TS_WIDTH=4, arm, only in[0] rises → done=1 and timeout=1 when counter reaches 15; ts_valid=0001.
- Arm collisions:
  - arm in the same cycle as edge_pulse[2] → ts_valid[2]=0;
  - re-arm in DONE → counter restarts at 0 and ts_valid clears;
  - rst_n low mid-ARMED → state IDLE and outputs 0 asynchronously.
